// File: rtl/core_memr.sv
// Memory-read stage: issues loads to the MMU, aligns/extends the returned word,
// and forwards register/CSR writes, stores and jumps with one cycle of latency.
module core_memr (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    input  logic [4:0]  C_REG_W_RD,
    input  logic [31:0] C_REG_W_DATA,
    input  logic [11:0] C_CSR_W_ADDR,
    input  logic [31:0] C_CSR_W_DATA,
    input  logic        C_MEM_R_EN,
    input  logic [4:0]  C_MEM_R_RD,
    input  logic [31:0] C_MEM_R_ADDR,
    input  logic [3:0]  C_MEM_R_STRB,
    input  logic        C_MEM_R_SIGNED,
    input  logic        C_MEM_W_EN,
    input  logic [31:0] C_MEM_W_ADDR,
    input  logic [3:0]  C_MEM_W_STRB,
    input  logic [31:0] C_MEM_W_DATA,
    input  logic        C_JMP_DO,
    input  logic [31:0] C_JMP_PC,
    input  logic        MEM_WAIT,
    output logic        DATA_RDEN,
    output logic [31:0] DATA_RIADDR,
    input  logic        DATA_RVALID,
    input  logic [31:0] DATA_ROADDR,
    input  logic [31:0] DATA_RDATA,
    output logic        STALL,
    output logic [4:0]  MEMR_REG_W_RD,
    output logic [31:0] MEMR_REG_W_DATA,
    output logic [11:0] MEMR_CSR_W_ADDR,
    output logic [31:0] MEMR_CSR_W_DATA,
    output logic        MEMR_MEM_W_EN,
    output logic [31:0] MEMR_MEM_W_ADDR,
    output logic [3:0]  MEMR_MEM_W_STRB,
    output logic [31:0] MEMR_MEM_W_DATA,
    output logic        MEMR_JMP_DO,
    output logic [31:0] MEMR_JMP_PC
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

    state_t      r_state, w_state_next;
    logic [4:0]  r_ld_rd;
    logic [31:0] r_ld_addr;
    logic [3:0]  r_ld_strb;
    logic        r_ld_signed;

    logic [4:0]  r_reg_w_rd,   w_reg_w_rd;
    logic [31:0] r_reg_w_data, w_reg_w_data;
    logic [11:0] r_csr_w_addr, w_csr_w_addr;
    logic [31:0] r_csr_w_data, w_csr_w_data;
    logic        r_mem_w_en,   w_mem_w_en;
    logic [31:0] r_mem_w_addr, w_mem_w_addr;
    logic [3:0]  r_mem_w_strb, w_mem_w_strb;
    logic [31:0] r_mem_w_data, w_mem_w_data;
    logic        r_jmp_do,     w_jmp_do;
    logic [31:0] r_jmp_pc,     w_jmp_pc;

    logic [31:0] w_aligned;
    logic        w_hit;
    logic        w_latch;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign w_aligned = {r_ld_addr[31:2], 2'b00};
    assign w_hit     = DATA_RVALID && (DATA_ROADDR == w_aligned);
    assign w_latch   = (r_state == S_IDLE) && C_MEM_R_EN && !FLUSH;

    // Halfword select uses only addr[1]; misaligned halves are not split.
    assign w_byte = DATA_RDATA[{r_ld_addr[1:0], 3'b000} +: 8];
    assign w_half = r_ld_addr[1] ? DATA_RDATA[31:16] : DATA_RDATA[15:0];

    always_comb begin
        case (r_ld_strb)
            4'b0001: w_ext = {{24{r_ld_signed & w_byte[7]}}, w_byte};
            4'b0011: w_ext = {{16{r_ld_signed & w_half[15]}}, w_half};
            default: w_ext = DATA_RDATA;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (C_MEM_R_EN && !FLUSH) w_state_next = S_REQ;
            S_REQ: begin
                if (!MEM_WAIT)  w_state_next = FLUSH ? S_DRAIN : S_WAIT;
                else if (FLUSH) w_state_next = S_IDLE;
            end
            // A hit coinciding with FLUSH consumes the response, so no drain is needed.
            S_WAIT: begin
                if (w_hit)      w_state_next = S_IDLE;
                else if (FLUSH) w_state_next = S_DRAIN;
            end
            S_DRAIN: if (DATA_RVALID) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic: next values of the output slot default to a bubble
    always_comb begin
        w_reg_w_rd   = '0;
        w_reg_w_data = '0;
        w_csr_w_addr = '0;
        w_csr_w_data = '0;
        w_mem_w_en   = 1'b0;
        w_mem_w_addr = '0;
        w_mem_w_strb = '0;
        w_mem_w_data = '0;
        w_jmp_do     = 1'b0;
        w_jmp_pc     = '0;
        if (!FLUSH) begin
            if (r_state == S_IDLE && !C_MEM_R_EN) begin
                w_reg_w_rd   = C_REG_W_RD;
                w_reg_w_data = C_REG_W_DATA;
                w_csr_w_addr = C_CSR_W_ADDR;
                w_csr_w_data = C_CSR_W_DATA;
                w_mem_w_en   = C_MEM_W_EN;
                w_mem_w_addr = C_MEM_W_ADDR;
                w_mem_w_strb = C_MEM_W_STRB;
                w_mem_w_data = C_MEM_W_DATA;
                w_jmp_do     = C_JMP_DO;
                w_jmp_pc     = C_JMP_PC;
            end else if (r_state == S_WAIT && w_hit) begin
                w_reg_w_rd   = r_ld_rd;
                w_reg_w_data = w_ext;
            end
        end
    end

    assign DATA_RDEN   = (r_state == S_REQ);
    assign DATA_RIADDR = w_aligned;
    assign STALL = RST && ((r_state == S_REQ) || (r_state == S_WAIT && !w_hit) ||
                           ((r_state == S_IDLE || r_state == S_DRAIN) && C_MEM_R_EN && !FLUSH));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ld_rd      <= '0;
            r_ld_addr    <= '0;
            r_ld_strb    <= '0;
            r_ld_signed  <= 1'b0;
            r_reg_w_rd   <= '0;
            r_reg_w_data <= '0;
            r_csr_w_addr <= '0;
            r_csr_w_data <= '0;
            r_mem_w_en   <= 1'b0;
            r_mem_w_addr <= '0;
            r_mem_w_strb <= '0;
            r_mem_w_data <= '0;
            r_jmp_do     <= 1'b0;
            r_jmp_pc     <= '0;
        end else begin
            if (w_latch) begin
                r_ld_rd     <= C_MEM_R_RD;
                r_ld_addr   <= C_MEM_R_ADDR;
                r_ld_strb   <= C_MEM_R_STRB;
                r_ld_signed <= C_MEM_R_SIGNED;
            end
            r_reg_w_rd   <= w_reg_w_rd;
            r_reg_w_data <= w_reg_w_data;
            r_csr_w_addr <= w_csr_w_addr;
            r_csr_w_data <= w_csr_w_data;
            r_mem_w_en   <= w_mem_w_en;
            r_mem_w_addr <= w_mem_w_addr;
            r_mem_w_strb <= w_mem_w_strb;
            r_mem_w_data <= w_mem_w_data;
            r_jmp_do     <= w_jmp_do;
            r_jmp_pc     <= w_jmp_pc;
        end
    end

    assign MEMR_REG_W_RD   = r_reg_w_rd;
    assign MEMR_REG_W_DATA = r_reg_w_data;
    assign MEMR_CSR_W_ADDR = r_csr_w_addr;
    assign MEMR_CSR_W_DATA = r_csr_w_data;
    assign MEMR_MEM_W_EN   = r_mem_w_en;
    assign MEMR_MEM_W_ADDR = r_mem_w_addr;
    assign MEMR_MEM_W_STRB = r_mem_w_strb;
    assign MEMR_MEM_W_DATA = r_mem_w_data;
    assign MEMR_JMP_DO     = r_jmp_do;
    assign MEMR_JMP_PC     = r_jmp_pc;

endmodule

// File: tb/tb_core_memr.sv
// Directed bench for core_memr: passthrough, loads of each size, flush/drain,
// store/jump forwarding and asynchronous reset in the middle of a load.
module tb_core_memr;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush;
    logic [4:0]  c_reg_w_rd;
    logic [31:0] c_reg_w_data;
    logic [11:0] c_csr_w_addr;
    logic [31:0] c_csr_w_data;
    logic        c_mem_r_en;
    logic [4:0]  c_mem_r_rd;
    logic [31:0] c_mem_r_addr;
    logic [3:0]  c_mem_r_strb;
    logic        c_mem_r_signed;
    logic        c_mem_w_en;
    logic [31:0] c_mem_w_addr;
    logic [3:0]  c_mem_w_strb;
    logic [31:0] c_mem_w_data;
    logic        c_jmp_do;
    logic [31:0] c_jmp_pc;
    logic        mem_wait;
    logic        data_rden;
    logic [31:0] data_riaddr;
    logic        data_rvalid;
    logic [31:0] data_roaddr;
    logic [31:0] data_rdata;
    logic        stall;
    logic [4:0]  memr_reg_w_rd;
    logic [31:0] memr_reg_w_data;
    logic [11:0] memr_csr_w_addr;
    logic [31:0] memr_csr_w_data;
    logic        memr_mem_w_en;
    logic [31:0] memr_mem_w_addr;
    logic [3:0]  memr_mem_w_strb;
    logic [31:0] memr_mem_w_data;
    logic        memr_jmp_do;
    logic [31:0] memr_jmp_pc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    core_memr dut (
        .CLK(clk), .RST(rst), .FLUSH(flush),
        .C_REG_W_RD(c_reg_w_rd), .C_REG_W_DATA(c_reg_w_data),
        .C_CSR_W_ADDR(c_csr_w_addr), .C_CSR_W_DATA(c_csr_w_data),
        .C_MEM_R_EN(c_mem_r_en), .C_MEM_R_RD(c_mem_r_rd), .C_MEM_R_ADDR(c_mem_r_addr),
        .C_MEM_R_STRB(c_mem_r_strb), .C_MEM_R_SIGNED(c_mem_r_signed),
        .C_MEM_W_EN(c_mem_w_en), .C_MEM_W_ADDR(c_mem_w_addr),
        .C_MEM_W_STRB(c_mem_w_strb), .C_MEM_W_DATA(c_mem_w_data),
        .C_JMP_DO(c_jmp_do), .C_JMP_PC(c_jmp_pc),
        .MEM_WAIT(mem_wait), .DATA_RDEN(data_rden), .DATA_RIADDR(data_riaddr),
        .DATA_RVALID(data_rvalid), .DATA_ROADDR(data_roaddr), .DATA_RDATA(data_rdata),
        .STALL(stall),
        .MEMR_REG_W_RD(memr_reg_w_rd), .MEMR_REG_W_DATA(memr_reg_w_data),
        .MEMR_CSR_W_ADDR(memr_csr_w_addr), .MEMR_CSR_W_DATA(memr_csr_w_data),
        .MEMR_MEM_W_EN(memr_mem_w_en), .MEMR_MEM_W_ADDR(memr_mem_w_addr),
        .MEMR_MEM_W_STRB(memr_mem_w_strb), .MEMR_MEM_W_DATA(memr_mem_w_data),
        .MEMR_JMP_DO(memr_jmp_do), .MEMR_JMP_PC(memr_jmp_pc)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        flush = 0; c_reg_w_rd = 0; c_reg_w_data = 0; c_csr_w_addr = 0; c_csr_w_data = 0;
        c_mem_r_en = 0; c_mem_r_rd = 0; c_mem_r_addr = 0; c_mem_r_strb = 0; c_mem_r_signed = 0;
        c_mem_w_en = 0; c_mem_w_addr = 0; c_mem_w_strb = 0; c_mem_w_data = 0;
        c_jmp_do = 0; c_jmp_pc = 0; mem_wait = 0;
        data_rvalid = 0; data_roaddr = 0; data_rdata = 0;
    endtask

    // Load with a zero-wait MMU that answers in the cycle after acceptance.
    task automatic load_zw(input string tag, input logic [4:0] rd, input logic [31:0] addr,
                           input logic [3:0] strb, input logic sgn, input logic [31:0] aligned,
                           input logic [31:0] rdata, input logic [31:0] exp);
        c_mem_r_en = 1; c_mem_r_rd = rd; c_mem_r_addr = addr;
        c_mem_r_strb = strb; c_mem_r_signed = sgn; mem_wait = 0;
        tick;
        check_val({tag, "_riaddr"}, data_riaddr, aligned);
        tick;
        data_rvalid = 1; data_roaddr = aligned; data_rdata = rdata;
        #1;
        check_val({tag, "_stall_hit"}, {31'b0, stall}, 32'd0);
        tick;
        c_mem_r_en = 0; data_rvalid = 0;
        check_val({tag, "_rd"}, {27'b0, memr_reg_w_rd}, {27'b0, rd});
        check_val({tag, "_data"}, memr_reg_w_data, exp);
        tick;
        check_val({tag, "_rd_once"}, {27'b0, memr_reg_w_rd}, 32'd0);
    endtask

    initial begin
        clear_inputs();
        c_mem_r_en = 1;
        #2;
        check_val("rst_stall", {31'b0, stall}, 32'd0);
        check_val("rst_rden", {31'b0, data_rden}, 32'd0);
        check_val("rst_rd", {27'b0, memr_reg_w_rd}, 32'd0);
        check_val("rst_data", memr_reg_w_data, 32'd0);
        check_val("rst_memw", {31'b0, memr_mem_w_en}, 32'd0);
        c_mem_r_en = 0;
        tick;
        rst = 1;

        // ALU and CSR passthrough
        c_reg_w_rd = 5; c_reg_w_data = 32'h0000_1234;
        c_csr_w_addr = 12'h300; c_csr_w_data = 32'h0000_CAFE;
        #1;
        check_val("alu_stall", {31'b0, stall}, 32'd0);
        tick;
        clear_inputs();
        check_val("alu_rd", {27'b0, memr_reg_w_rd}, 32'd5);
        check_val("alu_data", memr_reg_w_data, 32'h0000_1234);
        check_val("alu_csr_addr", {20'b0, memr_csr_w_addr}, 32'h300);
        check_val("alu_csr_data", memr_csr_w_data, 32'h0000_CAFE);
        tick;
        check_val("alu_bubble", {27'b0, memr_reg_w_rd}, 32'd0);

        // Signed byte load, MMU busy for one cycle, a stray response, then data
        c_mem_r_en = 1; c_mem_r_rd = 7; c_mem_r_addr = 32'h2000_0103;
        c_mem_r_strb = 4'b0001; c_mem_r_signed = 1;
        #1;
        check_val("sb_stall_idle", {31'b0, stall}, 32'd1);
        tick;
        mem_wait = 1;
        check_val("sb_rden", {31'b0, data_rden}, 32'd1);
        check_val("sb_riaddr", data_riaddr, 32'h2000_0100);
        check_val("sb_bubble", {27'b0, memr_reg_w_rd}, 32'd0);
        tick;
        mem_wait = 0;
        check_val("sb_rden_wait", {31'b0, data_rden}, 32'd1);
        tick;
        check_val("sb_rden_off", {31'b0, data_rden}, 32'd0);
        data_rvalid = 1; data_roaddr = 32'h2000_0200; data_rdata = 32'h1111_1111;
        #1;
        check_val("sb_stall_stray", {31'b0, stall}, 32'd1);
        tick;
        check_val("sb_stray_rd", {27'b0, memr_reg_w_rd}, 32'd0);
        data_roaddr = 32'h2000_0100; data_rdata = 32'h80FF_7F01;
        #1;
        check_val("sb_stall_hit", {31'b0, stall}, 32'd0);
        tick;
        clear_inputs();
        check_val("sb_rd", {27'b0, memr_reg_w_rd}, 32'd7);
        check_val("sb_data", memr_reg_w_data, 32'hFFFF_FF80);
        tick;
        check_val("sb_rd_once", {27'b0, memr_reg_w_rd}, 32'd0);

        load_zw("uh", 5'd8, 32'h2000_0012, 4'b0011, 1'b0, 32'h2000_0010, 32'h8001_0000, 32'h0000_8001);
        load_zw("uw", 5'd9, 32'h2000_0020, 4'b1111, 1'b0, 32'h2000_0020, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        load_zw("sh", 5'd10, 32'h2000_0011, 4'b0011, 1'b1, 32'h2000_0010, 32'h1234_F00D, 32'hFFFF_F00D);
        load_zw("ub", 5'd11, 32'h2000_0031, 4'b0001, 1'b0, 32'h2000_0030, 32'h80FF_7F01, 32'h0000_007F);
        load_zw("sw", 5'd12, 32'h2000_0042, 4'b1111, 1'b1, 32'h2000_0040, 32'h8000_0001, 32'h8000_0001);

        // Flush during WAIT: response discarded, then ALU passes
        c_mem_r_en = 1; c_mem_r_rd = 13; c_mem_r_addr = 32'h2000_0060; c_mem_r_strb = 4'b1111;
        tick;
        tick;
        flush = 1; c_mem_r_en = 0;
        tick;
        flush = 0;
        check_val("fl_bubble", {27'b0, memr_reg_w_rd}, 32'd0);
        #1;
        check_val("fl_drain_stall", {31'b0, stall}, 32'd0);
        tick;
        data_rvalid = 1; data_roaddr = 32'h2000_0060; data_rdata = 32'h7777_7777;
        tick;
        data_rvalid = 0;
        check_val("fl_drop_rd", {27'b0, memr_reg_w_rd}, 32'd0);
        c_reg_w_rd = 3; c_reg_w_data = 32'h0000_0055;
        tick;
        clear_inputs();
        check_val("fl_alu_rd", {27'b0, memr_reg_w_rd}, 32'd3);
        check_val("fl_alu_data", memr_reg_w_data, 32'h0000_0055);

        // Store + jump passthrough, then squashed by FLUSH
        c_mem_w_en = 1; c_mem_w_addr = 32'h2000_0040; c_mem_w_strb = 4'b1111;
        c_mem_w_data = 32'hA5A5_A5A5; c_jmp_do = 1; c_jmp_pc = 32'h2000_003C;
        tick;
        check_val("st_en", {31'b0, memr_mem_w_en}, 32'd1);
        check_val("st_addr", memr_mem_w_addr, 32'h2000_0040);
        check_val("st_strb", {28'b0, memr_mem_w_strb}, 32'hF);
        check_val("st_data", memr_mem_w_data, 32'hA5A5_A5A5);
        check_val("jmp_do", {31'b0, memr_jmp_do}, 32'd1);
        check_val("jmp_pc", memr_jmp_pc, 32'h2000_003C);
        flush = 1;
        tick;
        check_val("st_squash", {31'b0, memr_mem_w_en}, 32'd0);
        check_val("jmp_squash", {31'b0, memr_jmp_do}, 32'd0);
        clear_inputs();
        tick;

        // Asynchronous reset mid-WAIT, then a late response is ignored
        c_mem_r_en = 1; c_mem_r_rd = 4; c_mem_r_addr = 32'h2000_0050; c_mem_r_strb = 4'b1111;
        tick;
        tick;
        check_val("rw_stall_before", {31'b0, stall}, 32'd1);
        rst = 0;
        #1;
        check_val("rw_stall", {31'b0, stall}, 32'd0);
        check_val("rw_rden", {31'b0, data_rden}, 32'd0);
        check_val("rw_rd", {27'b0, memr_reg_w_rd}, 32'd0);
        c_mem_r_en = 0;
        tick;
        rst = 1;
        data_rvalid = 1; data_roaddr = 32'h2000_0050; data_rdata = 32'h4444_4444;
        tick;
        data_rvalid = 0;
        check_val("rw_late_rd", {27'b0, memr_reg_w_rd}, 32'd0);
        check_val("rw_late_rden", {31'b0, data_rden}, 32'd0);
        check_val("rw_late_stall", {31'b0, stall}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
